// File: rtl/snn_fp_pkg.sv
// Shared definitions for the potential-decay sequencer: sweep FSM states and
// IEEE-754 single-precision field positions.
package snn_fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_WB = 2'd2,
        ST_FINISH  = 2'd3
    } seq_state_e;

    localparam int FP32_W  = 32;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int EXP_MAX = 255;

endpackage

// File: rtl/fp32_pow2_decay.sv
// Combinational multiply of an FP32 value by 2^-DECAY_SHIFT via exponent
// subtraction; underflow flushes to +0 and Inf/NaN pass through.
module fp32_pow2_decay
    import snn_fp_pkg::*;
#(
    parameter int DECAY_SHIFT = 1
) (
    input  logic [FP32_W-1:0] potential,
    output logic [FP32_W-1:0] decayed
);

    localparam logic [7:0] SHIFT_EXP = 8'(DECAY_SHIFT);
    localparam logic [7:0] INF_EXP   = 8'(EXP_MAX);

    function automatic logic [FP32_W-1:0] pow2_decay(input logic [FP32_W-1:0] v);
        logic [7:0]        exp_f;
        logic [FP32_W-1:0] res;
        exp_f = v[EXP_MSB:EXP_LSB];
        if (exp_f == INF_EXP) begin
            res = v;
        end else if (exp_f <= SHIFT_EXP) begin
            // Zero, denormals and anything that would leave the normal range.
            res = '0;
        end else begin
            res = {v[FP32_W-1], exp_f - SHIFT_EXP, v[EXP_LSB-1:0]};
        end
        return res;
    endfunction

    assign decayed = pow2_decay(potential);

endmodule

// File: rtl/potential_decay_sequencer.sv
// Sweeps all neurons once per timestep: issues each decayed potential to an
// external adder stage and stores the returned potential and spike.
module potential_decay_sequencer
    import snn_fp_pkg::*;
#(
    parameter int N_NEURONS   = 16,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         timestep,
    output logic                         busy,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [$clog2(N_NEURONS)-1:0] issue_id,
    output logic [FP32_W-1:0]            decayed_potential,
    input  logic                         wb_valid,
    input  logic [FP32_W-1:0]            wb_potential,
    input  logic                         wb_spike,
    output logic [N_NEURONS-1:0]         spike_vector,
    output logic                         done
);

    localparam int               IDX_W    = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    seq_state_e             state_q;
    seq_state_e             state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [FP32_W-1:0]      potential_q [N_NEURONS];
    logic [N_NEURONS-1:0]   spike_acc_q;
    logic [N_NEURONS-1:0]   spike_vector_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   wb_accept;

    assign wb_accept = (state_q == ST_WAIT_WB) && wb_valid;

    always_comb begin
        state_d     = state_q;
        issue_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (timestep) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) state_d = ST_WAIT_WB;
            end
            ST_WAIT_WB: begin
                if (wb_valid) state_d = (idx_q == LAST_IDX) ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control: state, index, spike bookkeeping and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            spike_acc_q    <= '0;
            spike_vector_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (timestep) begin
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        spike_acc_q <= '0;
                    end
                end
                ST_WAIT_WB: begin
                    if (wb_valid) begin
                        spike_acc_q[idx_q] <= wb_spike;
                        if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    spike_vector_q <= spike_acc_q;
                    done_q         <= 1'b1;
                    busy_q         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Potential storage, written only by an accepted write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) potential_q[i] <= '0;
        end else if (wb_accept) begin
            potential_q[idx_q] <= wb_potential;
        end
    end

    fp32_pow2_decay #(
        .DECAY_SHIFT(DECAY_SHIFT)
    ) u_decay (
        .potential(potential_q[idx_q]),
        .decayed  (decayed_potential)
    );

    assign issue_id     = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign spike_vector = spike_vector_q;

endmodule

// File: tb/tb_potential_decay_sequencer.sv
// Directed-plus-random bench for potential_decay_sequencer against a
// value-level model of stored potentials, decay and spikes.
module tb_potential_decay_sequencer;

    localparam int N     = 16;
    localparam int SHIFT = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          timestep = 1'b0;
    logic          busy;
    logic          issue_valid;
    logic          issue_ready = 1'b0;
    logic [3:0]    issue_id;
    logic [31:0]   decayed_potential;
    logic          wb_valid = 1'b0;
    logic [31:0]   wb_potential = '0;
    logic          wb_spike = 1'b0;
    logic [N-1:0]  spike_vector;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [31:0]  model_pot [N];
    logic [N-1:0] model_sv;
    logic [31:0]  wb_val [N];
    logic [N-1:0] wb_spk;
    logic [31:0]  issued [N];

    potential_decay_sequencer #(.N_NEURONS(N), .DECAY_SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .timestep(timestep), .busy(busy),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
        .decayed_potential(decayed_potential), .wb_valid(wb_valid),
        .wb_potential(wb_potential), .wb_spike(wb_spike),
        .spike_vector(spike_vector), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value-level reference: scale by 2^-SHIFT in real arithmetic, with
    // underflow to +0 and Inf/NaN untouched.
    function automatic logic [31:0] ref_decay(input logic [31:0] v);
        int          e;
        logic [63:0] d;
        real         r;
        int          de;
        e = int'(v[30:23]);
        if (e == 255) return v;
        if (e <= SHIFT) return 32'h0;
        d = {v[31], 11'(e - 127 + 1023), v[22:0], 29'b0};
        r = $bitstoreal(d) / real'(1 << SHIFT);
        d = $realtobits(r);
        de = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(de), d[51:29]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'(SHIFT);
            2:       e = 8'd255;
            default: e = 8'($urandom_range(2, 254));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_pot[i] = '0;
        model_sv = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  {31'b0, busy}, 32'd0);
        check({tag, "_valid"}, {31'b0, issue_valid}, 32'd0);
        check({tag, "_done"},  {31'b0, done}, 32'd0);
        check({tag, "_id"},    {28'b0, issue_id}, 32'd0);
        check({tag, "_data"},  decayed_potential, 32'd0);
        check({tag, "_spk"},   {16'b0, spike_vector}, 32'd0);
    endtask

    // One sweep. stall_id gets ready held low for stall_n cycles (with a
    // stray write-back offered meanwhile); glitch_id gets a second timestep
    // during its write-back; abort_id gets rst_n pulled during WAIT_WB.
    task automatic run_sweep(input int stall_id, input int stall_n,
                             input int glitch_id, input int abort_id);
        int cyc;
        @(negedge clk);
        timestep = 1'b1;
        @(posedge clk); #1;
        timestep = 1'b0;
        cyc = 0;
        check("busy_start", {31'b0, busy}, 32'd1);
        for (int i = 0; i < N; i++) begin
            check("issue_valid", {31'b0, issue_valid}, 32'd1);
            check("issue_id", {28'b0, issue_id}, 32'(i));
            check("issue_data", decayed_potential, ref_decay(model_pot[i]));
            check("sv_hold", {16'b0, spike_vector}, {16'b0, model_sv});
            issued[i] = decayed_potential;
            if (i == stall_id) begin
                issue_ready = 1'b0;
                wb_valid = 1'b1; wb_potential = 32'hDEADBEEF; wb_spike = 1'b1;
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1; cyc++;
                    check("stall_valid", {31'b0, issue_valid}, 32'd1);
                    check("stall_id", {28'b0, issue_id}, 32'(i));
                    check("stall_data", decayed_potential, issued[i]);
                end
                wb_valid = 1'b0; wb_spike = 1'b0;
            end
            issue_ready = 1'b1;
            @(posedge clk); #1; cyc++;
            issue_ready = 1'b0;
            check("wait_no_valid", {31'b0, issue_valid}, 32'd0);
            if (i == abort_id) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_reset_outputs("abort");
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check("abort_no_done", {31'b0, done}, 32'd0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            wb_valid = 1'b1; wb_potential = wb_val[i]; wb_spike = wb_spk[i];
            if (i == glitch_id) timestep = 1'b1;
            @(posedge clk); #1; cyc++;
            wb_valid = 1'b0; wb_spike = 1'b0; timestep = 1'b0;
            model_pot[i] = wb_val[i];
            if (i != N - 1) check("no_early_done", {31'b0, done}, 32'd0);
        end
        @(posedge clk); #1; cyc++;
        model_sv = wb_spk;
        check("done", {31'b0, done}, 32'd1);
        check("latency", 32'(cyc), 32'(2 * N + 1 + ((stall_id >= 0) ? stall_n : 0)));
        check("spike_vector", {16'b0, spike_vector}, {16'b0, model_sv});
        check("busy_end", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check("done_pulse", {31'b0, done}, 32'd0);
        check("idle_after", {31'b0, issue_valid}, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero sweep, write-back echoes the decayed value.
        for (int i = 0; i < N; i++) wb_val[i] = ref_decay(model_pot[i]);
        wb_spk = '0;
        run_sweep(-1, 0, -1, -1);

        // Preload neuron 3 with 100.0 plus random neighbours.
        for (int i = 0; i < N; i++) wb_val[i] = rand_fp();
        wb_val[3] = 32'h42C80000;
        wb_val[4] = 32'h00800000;
        wb_val[5] = 32'h7F800000;
        wb_spk = 16'($urandom);
        run_sweep(-1, 0, -1, -1);

        // Decay of preloaded values, with a 5-cycle stall at id 2.
        for (int i = 0; i < N; i++) wb_val[i] = rand_fp();
        wb_spk = 16'h8001;
        run_sweep(2, 5, 6, -1);
        check("decay_100", issued[3], 32'h42480000);
        check("decay_min_norm", issued[4], 32'h00000000);
        check("decay_inf", issued[5], 32'h7F800000);
        check("spk_8001", {16'b0, spike_vector}, 32'h00008001);

        // Random sweeps with random stalls.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) wb_val[i] = rand_fp();
            wb_spk = 16'($urandom);
            run_sweep(int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)), -1, -1);
        end

        // Reset in WAIT_WB at id 7, then a fresh sweep from id 0.
        for (int i = 0; i < N; i++) wb_val[i] = rand_fp();
        wb_spk = 16'($urandom);
        run_sweep(-1, 0, -1, 7);
        check_reset_outputs("post_abort");
        for (int i = 0; i < N; i++) wb_val[i] = rand_fp();
        wb_spk = 16'($urandom);
        run_sweep(-1, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
